// File: rtl/keycode_pkg.sv
// -----------------------------------------------------------------------------
// keycode_pkg
// Shared constants and types for the PS/2 keycode tracker:
//   - bit positions of the six player actions in the held-key mask
//   - scancode byte values (prefixes, mapped keys, error bytes)
//   - decoder FSM state encoding
// -----------------------------------------------------------------------------
package keycode_pkg;

    // Held-key mask bit positions. Bits 7 and 3 are never driven.
    localparam logic [2:0] BIT_FB_JUMP  = 3'd6;
    localparam logic [2:0] BIT_FB_LEFT  = 3'd5;
    localparam logic [2:0] BIT_FB_RIGHT = 3'd4;
    localparam logic [2:0] BIT_IG_JUMP  = 3'd2;
    localparam logic [2:0] BIT_IG_LEFT  = 3'd1;
    localparam logic [2:0] BIT_IG_RIGHT = 3'd0;

    // Prefix bytes.
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    // Fireboy keys (extended arrows).
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Icegirl keys (plain W/A/D).
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // Keyboard error / overrun bytes.
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    // Bytes following E1 in the Pause sequence (14 77 E1 F0 14 F0 77).
    localparam logic [2:0] SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

endpackage

// File: rtl/keycode_tracker_scancode_lookup.sv
// -----------------------------------------------------------------------------
// scancode_lookup
// Combinational map from a terminal scancode byte (plus its E0 status) to
// the held-key mask bit it controls.
//   code    : in  8  terminal scancode byte
//   ext     : in  1  byte was preceded by E0
//   hit     : out 1  byte/ext pair is one of the six mapped keys
//   bit_idx : out 3  mask bit position for the key (0 when no hit)
// -----------------------------------------------------------------------------
module scancode_lookup
    import keycode_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic       hit,
    output logic [2:0] bit_idx
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        hit     = 1'b0;
        bit_idx = 3'd0;
        if (ext) begin
            case (code)
                SC_UP:    begin hit = 1'b1; bit_idx = BIT_FB_JUMP;  end
                SC_LEFT:  begin hit = 1'b1; bit_idx = BIT_FB_LEFT;  end
                SC_RIGHT: begin hit = 1'b1; bit_idx = BIT_FB_RIGHT; end
                default:  ;
            endcase
        end else begin
            case (code)
                SC_W:     begin hit = 1'b1; bit_idx = BIT_IG_JUMP;  end
                SC_A:     begin hit = 1'b1; bit_idx = BIT_IG_LEFT;  end
                SC_D:     begin hit = 1'b1; bit_idx = BIT_IG_RIGHT; end
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/keycode_tracker.sv
// -----------------------------------------------------------------------------
// keycode_tracker
// Decodes the PS/2 scancode byte stream (make, F0 break, E0 extended, E1
// Pause) into an 8-bit held-key mask for the two players.
//   Clk        : in  1  system clock
//   Reset      : in  1  synchronous active-high reset
//   scan_valid : in  1  one-cycle strobe, scan_data valid
//   scan_data  : in  8  received scancode byte
//   keycode    : out 8  registered held-key mask
//   key_event  : out 1  one-cycle pulse when keycode changes
// Parameter TIMEOUT_CYCLES: idle cycles in a prefix state before the
// partial sequence is abandoned.
// -----------------------------------------------------------------------------
module keycode_tracker
    import keycode_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_data,
    output logic [7:0] keycode,
    output logic       key_event
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t           state, state_next;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_next;
    logic [2:0]       skip_cnt, skip_cnt_next;
    logic [7:0]       mask_next;

    logic       is_err;
    logic       is_ext;
    logic       is_break;
    logic       terminal;
    logic       hit;
    logic [2:0] bit_idx;

    // Error bytes abort any sequence except Pause, whose payload is opaque.
    assign is_err   = scan_valid && (state != SKIP) &&
                      ((scan_data == SC_ERR_LO) || (scan_data == SC_ERR_HI));
    assign is_ext   = (state == EXT) || (state == EXT_BRK);
    assign is_break = (state == BRK) || (state == EXT_BRK);

    scancode_lookup u_lookup (
        .code    (scan_data),
        .ext     (is_ext),
        .hit     (hit),
        .bit_idx (bit_idx)
    );

    // State, counters and mask register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            skip_cnt  <= '0;
            keycode   <= 8'h00;
            key_event <= 1'b0;
        end else begin
            state     <= state_next;
            tmo_cnt   <= tmo_cnt_next;
            skip_cnt  <= skip_cnt_next;
            keycode   <= mask_next;
            key_event <= (mask_next != keycode);
        end
    end

    // Next-state logic, skip counter and timeout counter.
    always_comb begin
        state_next    = state;
        skip_cnt_next = skip_cnt;

        if (is_err) begin
            state_next = IDLE;
        end else if (scan_valid) begin
            case (state)
                IDLE: begin
                    case (scan_data)
                        SC_EXT:   state_next = EXT;
                        SC_BRK:   state_next = BRK;
                        SC_PAUSE: begin
                            state_next    = SKIP;
                            skip_cnt_next = SKIP_LEN;
                        end
                        default:  state_next = IDLE;
                    endcase
                end
                EXT:     state_next = (scan_data == SC_BRK) ? EXT_BRK : IDLE;
                BRK:     state_next = IDLE;
                EXT_BRK: state_next = IDLE;
                SKIP: begin
                    skip_cnt_next = skip_cnt - 3'd1;
                    if (skip_cnt_next == 3'd0) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if ((state != IDLE) && (tmo_cnt == TMO_MAX)) begin
            // A byte in the same cycle takes the branch above instead.
            state_next = IDLE;
        end

        // Held at 0 in IDLE, cleared by any byte, saturates at TMO_MAX.
        if (scan_valid || (state == IDLE)) begin
            tmo_cnt_next = '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt_next = tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt_next = tmo_cnt;
        end
    end

    // A terminal byte is any byte that completes a make/break in the
    // current state, i.e. one that is not a further prefix.
    always_comb begin
        terminal = 1'b0;
        if (scan_valid && !is_err) begin
            case (state)
                IDLE:    terminal = (scan_data != SC_EXT) && (scan_data != SC_BRK) &&
                                    (scan_data != SC_PAUSE);
                EXT:     terminal = (scan_data != SC_BRK);
                BRK:     terminal = 1'b1;
                EXT_BRK: terminal = 1'b1;
                default: terminal = 1'b0;
            endcase
        end
    end

    // Mask update: set on make, clear on break, wipe on error byte.
    // Repeated makes rewrite the same bit, so keycode and key_event hold.
    always_comb begin
        mask_next = keycode;
        if (is_err) begin
            mask_next = 8'h00;
        end else if (terminal && hit) begin
            mask_next[bit_idx] = !is_break;
        end
    end

endmodule

// File: tb/tb_keycode_tracker.sv
// -----------------------------------------------------------------------------
// tb_keycode_tracker
// Directed bench for keycode_tracker: a table of back-to-back bytes with
// hand-computed mask/event values, followed by hand-written sequences for
// Pause skipping, timeout, byte-vs-timeout race and mid-sequence reset.
// -----------------------------------------------------------------------------
module tb_keycode_tracker;
    import keycode_pkg::*;

    localparam int TO = 20;

    logic       Clk;
    logic       Reset;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic [7:0] keycode;
    logic       key_event;

    int n_checks = 0;
    int n_fail   = 0;

    keycode_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .keycode    (keycode),
        .key_event  (key_event)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] key;
        logic       evt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic [7:0] k, input logic e);
        vec_t v;
        v.data = d;
        v.key  = k;
        v.evt  = e;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the next negedge, just after the byte
    // has been sampled. Consecutive calls give back-to-back strobes.
    task automatic send(input logic [7:0] d, input logic [7:0] k, input logic e,
                        input string tag);
        scan_valid = 1'b1;
        scan_data  = d;
        @(negedge Clk);
        scan_valid = 1'b0;
        check({tag, " keycode"}, 32'(keycode), 32'(k));
        check({tag, " key_event"}, 32'(key_event), 32'(e));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check_state(input string name, input state_t exp);
        check(name, 32'(dut.state), 32'(exp));
    endtask

    initial begin
        // W make / break
        add(8'h1D, 8'h04, 1'b1); add(8'hF0, 8'h04, 1'b0); add(8'h1D, 8'h00, 1'b1);
        // Fireboy up + left, release up, bare 75 ignored, release left
        add(8'hE0, 8'h00, 1'b0); add(8'h75, 8'h40, 1'b1);
        add(8'hE0, 8'h40, 1'b0); add(8'h6B, 8'h60, 1'b1);
        add(8'hE0, 8'h60, 1'b0); add(8'hF0, 8'h60, 1'b0); add(8'h75, 8'h20, 1'b1);
        add(8'h75, 8'h20, 1'b0);
        add(8'hE0, 8'h20, 1'b0); add(8'hF0, 8'h20, 1'b0); add(8'h6B, 8'h00, 1'b1);
        // W, A, D then typematic W x5
        add(8'h1D, 8'h04, 1'b1); add(8'h1C, 8'h06, 1'b1); add(8'h23, 8'h07, 1'b1);
        for (int i = 0; i < 5; i++) add(8'h1D, 8'h07, 1'b0);
        // unmapped, fake shift E0 12 and E0 F0 12, extended W
        add(8'h12, 8'h07, 1'b0);
        add(8'hE0, 8'h07, 1'b0); add(8'h12, 8'h07, 1'b0);
        add(8'hE0, 8'h07, 1'b0); add(8'hF0, 8'h07, 1'b0); add(8'h12, 8'h07, 1'b0);
        add(8'hE0, 8'h07, 1'b0); add(8'h1D, 8'h07, 1'b0);
        // release W, A, D
        add(8'hF0, 8'h07, 1'b0); add(8'h1D, 8'h03, 1'b1);
        add(8'hF0, 8'h03, 1'b0); add(8'h1C, 8'h01, 1'b1);
        add(8'hF0, 8'h01, 1'b0); add(8'h23, 8'h00, 1'b1);
        // extended typematic
        add(8'hE0, 8'h00, 1'b0); add(8'h75, 8'h40, 1'b1);
        add(8'hE0, 8'h40, 1'b0); add(8'h75, 8'h40, 1'b0);
        add(8'hE0, 8'h40, 1'b0); add(8'hF0, 8'h40, 1'b0); add(8'h75, 8'h00, 1'b1);
        // W + Fireboy right, then FF wipes everything
        add(8'h1D, 8'h04, 1'b1); add(8'hE0, 8'h04, 1'b0); add(8'h74, 8'h14, 1'b1);
        add(8'hFF, 8'h00, 1'b1);
        // 00 after E0 wipes and returns to IDLE, so 75 is then bare
        add(8'h1C, 8'h02, 1'b1); add(8'hE0, 8'h02, 1'b0); add(8'h00, 8'h00, 1'b1);
        add(8'h75, 8'h00, 1'b0);
        add(8'h00, 8'h00, 1'b0);

        Reset      = 1'b1;
        scan_valid = 1'b0;
        scan_data  = 8'h00;
        idle(3);
        Reset = 1'b0;
        check("reset keycode", 32'(keycode), 32'h00);
        check("reset key_event", 32'(key_event), 32'h0);
        check_state("reset state", IDLE);
        idle(1);

        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].key, vecs[i].evt, $sformatf("vec%0d", i));
        end
        check_state("table end state", IDLE);
        idle(2);

        // Pause sequence while A held
        send(8'h1C, 8'h02, 1'b1, "pause A make");
        begin
            logic [7:0] pause_seq [8];
            pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            for (int i = 0; i < 8; i++) send(pause_seq[i], 8'h02, 1'b0, $sformatf("pause%0d", i));
        end
        check_state("pause end state", IDLE);
        send(8'hF0, 8'h02, 1'b0, "pause F0");
        send(8'h1C, 8'h00, 1'b1, "pause A break");

        // Error bytes inside SKIP are payload, not errors
        send(8'h1C, 8'h02, 1'b1, "skipff A make");
        send(8'hE1, 8'h02, 1'b0, "skipff E1");
        for (int i = 0; i < 7; i++) send(8'hFF, 8'h02, 1'b0, $sformatf("skipff%0d", i));
        check_state("skipff end state", IDLE);
        send(8'hF0, 8'h02, 1'b0, "skipff F0");
        send(8'h1C, 8'h00, 1'b1, "skipff A break");
        idle(1);
        check("key_event one cycle", 32'(key_event), 32'h0);

        // Timeout after E0: still EXT at TO idle cycles, IDLE at TO+1
        send(8'hE0, 8'h00, 1'b0, "tmo E0");
        idle(TO);
        check_state("tmo not yet", EXT);
        idle(1);
        check_state("tmo fired", IDLE);
        send(8'h1D, 8'h04, 1'b1, "tmo W make");
        send(8'hF0, 8'h04, 1'b0, "tmo F0");
        send(8'h1D, 8'h00, 1'b1, "tmo W break");

        // Byte arriving on the cycle the timeout would fire is decoded as extended
        send(8'hE0, 8'h00, 1'b0, "race E0");
        idle(TO);
        send(8'h75, 8'h40, 1'b1, "race up make");
        check_state("race state", IDLE);
        send(8'hE0, 8'h40, 1'b0, "race E0b");
        send(8'hF0, 8'h40, 1'b0, "race F0");
        send(8'h75, 8'h00, 1'b1, "race up break");

        // SKIP also times out; counter saturates rather than wrapping
        send(8'hE1, 8'h00, 1'b0, "skiptmo E1");
        idle(TO + 40);
        check_state("skiptmo state", IDLE);
        send(8'h1D, 8'h04, 1'b1, "skiptmo W make");
        send(8'hF0, 8'h04, 1'b0, "skiptmo F0");
        send(8'h1D, 8'h00, 1'b1, "skiptmo W break");

        // Reset after a lone F0 discards the prefix
        send(8'hF0, 8'h00, 1'b0, "rst F0");
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        check_state("rst state", IDLE);
        check("rst keycode", 32'(keycode), 32'h00);
        send(8'h1D, 8'h04, 1'b1, "rst W make");

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
